// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bundle: instruction/branch information toward the controller,
// pipeline-register controls back toward the core.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_load;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_store;
    logic              id_is_branch;
    logic              br_resolved;
    logic              pc_hold;
    logic              ifid_hold;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              load_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load,
               id_rd, id_is_store, id_is_branch, br_resolved,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, load_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_load,
               id_rd, id_is_store, id_is_branch, br_resolved,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, load_stall
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and branch-flush controller for the 5-stage core.
// Optional HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned BR_PENALTY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int unsigned CNT_W = $clog2(BR_PENALTY + 1);

    typedef enum logic {RUN, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOAD_LAT-1:0] ld_vld_q, ld_vld_d;
    logic [REG_AW-1:0]  ld_rd_q [LOAD_LAT];
    logic [REG_AW-1:0]  ld_rd_d [LOAD_LAT];

    logic rs_hit, rt_hit, stall_raw, issue, in_run, in_flush;

    // Source-vs-tracker match; store data hitting the oldest load is forwarded mem-to-mem
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (ld_vld_q[k] && hz.id_uses_rs && (hz.id_rs != '0) && (hz.id_rs == ld_rd_q[k]))
                rs_hit = 1'b1;
            if (ld_vld_q[k] && hz.id_uses_rt && (hz.id_rt != '0) && (hz.id_rt == ld_rd_q[k]) &&
                !(hz.id_is_store && (k == int'(LOAD_LAT) - 1)))
                rt_hit = 1'b1;
        end
    end

    assign in_run    = (state_q == RUN);
    assign in_flush  = (state_q == FLUSH);
    assign stall_raw = hz.id_valid & in_run & (rs_hit | rt_hit);
    assign issue     = hz.id_valid & ~stall_raw & in_run;

    assign hz.load_stall  = rst_n & stall_raw;
    assign hz.ifid_hold   = rst_n & stall_raw;
    assign hz.ifid_flush  = rst_n & in_flush;
    assign hz.pc_hold     = rst_n & (stall_raw | in_flush);
    assign hz.idex_bubble = rst_n & (stall_raw | in_flush);

    // Tracker aging and branch-flush sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_vld_d    = '0;
        ld_rd_d     = ld_rd_q;
        ld_vld_d[0] = issue & hz.id_is_load & (hz.id_rd != '0);
        ld_rd_d[0]  = hz.id_rd;
        for (int k = 1; k < int'(LOAD_LAT); k++) begin
            ld_vld_d[k] = ld_vld_q[k-1];
            ld_rd_d[k]  = ld_rd_q[k-1];
        end
        case (state_q)
            RUN: begin
                if (issue && hz.id_is_branch) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(BR_PENALTY);
                end
            end
            FLUSH: begin
                if (hz.br_resolved || (cnt_q == CNT_W'(1))) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d    = stall_cnt_q + 32'(stall_raw);
    assign flush_cnt_d    = flush_cnt_q + 32'(in_flush);
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ld_vld_q <= '0;
            ld_rd_q  <= '{default: '0};
`ifdef HAZARD_PERF_EN
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_vld_q <= ld_vld_d;
            ld_rd_q  <= ld_rd_d;
`ifdef HAZARD_PERF_EN
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: DUT a has LOAD_LAT=1, DUT b has LOAD_LAT=3, both BR_PENALTY=2.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) if_a ();
    hazard_ctrl_if #(.REG_AW(5)) if_b ();

`ifdef HAZARD_PERF_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_PENALTY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .hz(if_a.slave)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(a_stall_cnt), .perf_flush_cnt(a_flush_cnt)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_PENALTY(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .hz(if_b.slave)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(b_stall_cnt), .perf_flush_cnt(b_flush_cnt)
`endif
    );

    typedef struct packed {
        logic       v, urs, urt, ld, st, br, res;
        logic [4:0] rs, rt, rd;
    } id_t;

    typedef struct {
        bit         sel;
        logic [4:0] exp;
        string      name;
    } exp_t;

    // expected {load_stall, pc_hold, ifid_hold, idex_bubble, ifid_flush}
    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] S = 5'b11110;
    localparam logic [4:0] F = 5'b01011;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    function automatic id_t nop();
        id_t t = '0;
        return t;
    endfunction
    function automatic id_t lw(input logic [4:0] rd);
        id_t t = '0;
        t.v = 1'b1; t.ld = 1'b1; t.rd = rd;
        return t;
    endfunction
    function automatic id_t alu(input logic [4:0] rs, input logic [4:0] rt);
        id_t t = '0;
        t.v = 1'b1; t.urs = 1'b1; t.urt = 1'b1; t.rs = rs; t.rt = rt;
        return t;
    endfunction
    function automatic id_t alu_nors(input logic [4:0] rs);
        id_t t = '0;
        t.v = 1'b1; t.rs = rs;
        return t;
    endfunction
    function automatic id_t sw(input logic [4:0] base, input logic [4:0] data);
        id_t t = alu(base, data);
        t.st = 1'b1;
        return t;
    endfunction
    function automatic id_t br(input logic [4:0] rs, input logic [4:0] rt);
        id_t t = alu(rs, rt);
        t.br = 1'b1;
        return t;
    endfunction
    function automatic id_t resolved();
        id_t t = '0;
        t.res = 1'b1;
        return t;
    endfunction

    task automatic set_a(input id_t t);
        if_a.id_valid = t.v;   if_a.id_uses_rs = t.urs; if_a.id_uses_rt = t.urt;
        if_a.id_is_load = t.ld; if_a.id_is_store = t.st; if_a.id_is_branch = t.br;
        if_a.br_resolved = t.res; if_a.id_rs = t.rs; if_a.id_rt = t.rt; if_a.id_rd = t.rd;
    endtask
    task automatic set_b(input id_t t);
        if_b.id_valid = t.v;   if_b.id_uses_rs = t.urs; if_b.id_uses_rt = t.urt;
        if_b.id_is_load = t.ld; if_b.id_is_store = t.st; if_b.id_is_branch = t.br;
        if_b.br_resolved = t.res; if_b.id_rs = t.rs; if_b.id_rt = t.rt; if_b.id_rd = t.rd;
    endtask

    // One ID cycle on the selected DUT (other idles); expectation goes to the scoreboard
    task automatic step(input bit sel, input logic rstn, input id_t t,
                        input logic [4:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rstn;
        if (sel) begin set_b(t); set_a(nop()); end
        else     begin set_a(t); set_b(nop()); end
        e.sel = sel; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare the presented control outputs each cycle against the queue head
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] act;
        cyc <= cyc + 1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.sel ? {if_b.load_stall, if_b.pc_hold, if_b.ifid_hold, if_b.idex_bubble, if_b.ifid_flush}
                        : {if_a.load_stall, if_a.pc_hold, if_a.ifid_hold, if_a.idex_bubble, if_a.ifid_flush};
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s dut=%s cyc=%0d got=%b want=%b (ls,pc,ifh,bub,ifl)",
                         e.name, e.sel ? "b" : "a", cyc, act, e.exp);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        set_a(nop());
        set_b(nop());

        // reset: outputs gated even with a hazardous-looking ID
        step(0, 1'b0, lw(5'd1), N, "reset0");
        step(0, 1'b0, alu(5'd1, 5'd1), N, "reset1");
        step(0, 1'b1, nop(), N, "reset_rel");

        // LOAD_LAT=1 load-use: one stall then issue
        step(0, 1'b1, lw(5'd1), N, "a_lw_r1");
        step(0, 1'b1, alu(5'd1, 5'd3), S, "a_use_stall");
        step(0, 1'b1, alu(5'd1, 5'd3), N, "a_use_issue");
        step(0, 1'b1, nop(), N, "a_idle");

        // store exemption vs store base dependency
        step(0, 1'b1, lw(5'd7), N, "a_lw_r7");
        step(0, 1'b1, sw(5'd8, 5'd7), N, "a_sw_data_exempt");
        step(0, 1'b1, lw(5'd7), N, "a_lw_r7b");
        step(0, 1'b1, sw(5'd7, 5'd9), S, "a_sw_base_stall");
        step(0, 1'b1, sw(5'd7, 5'd9), N, "a_sw_base_issue");

        // r0 and unused sources never stall
        step(0, 1'b1, lw(5'd0), N, "a_lw_r0");
        step(0, 1'b1, alu(5'd0, 5'd0), N, "a_use_r0");
        step(0, 1'b1, lw(5'd5), N, "a_lw_r5");
        step(0, 1'b1, alu_nors(5'd5), N, "a_rs_unused");

        // branch, full penalty; loads offered during FLUSH are ignored
        step(0, 1'b1, br(5'd1, 5'd2), N, "a_beq_issue");
        step(0, 1'b1, lw(5'd3), F, "a_flush1");
        step(0, 1'b1, lw(5'd3), F, "a_flush2");
        step(0, 1'b1, alu(5'd3, 5'd0), N, "a_after_flush");

        // branch resolved in first FLUSH cycle
        step(0, 1'b1, br(5'd1, 5'd2), N, "a_beq2_issue");
        step(0, 1'b1, resolved(), F, "a_flush_res");
        step(0, 1'b1, nop(), N, "a_after_res");

        // branch with load hazard stalls first, then flushes
        step(0, 1'b1, lw(5'd6), N, "a_lw_r6");
        step(0, 1'b1, br(5'd6, 5'd0), S, "a_beq_stall");
        step(0, 1'b1, br(5'd6, 5'd0), N, "a_beq_issue3");
        step(0, 1'b1, nop(), F, "a_flush3a");
        step(0, 1'b1, nop(), F, "a_flush3b");
        step(0, 1'b1, nop(), N, "a_run3");

        // reset mid-FLUSH aborts the flush
        step(0, 1'b1, br(5'd1, 5'd2), N, "a_beq4_issue");
        step(0, 1'b0, nop(), N, "a_rst_in_flush");
        step(0, 1'b1, alu(5'd1, 5'd2), N, "a_run_after_rst");
        step(0, 1'b1, alu(5'd1, 5'd2), N, "a_run_after_rst2");

        // reset mid-stall discards the pending load
        step(0, 1'b1, lw(5'd1), N, "a_lw_r1_pre_rst");
        step(0, 1'b0, alu(5'd1, 5'd2), N, "a_rst_in_stall");
        step(0, 1'b1, alu(5'd1, 5'd2), N, "a_no_stale_stall");
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        check_perf("a_perf_stall_clr", a_stall_cnt, 32'd0);
        check_perf("a_perf_flush_clr", a_flush_cnt, 32'd0);
`endif

        // LOAD_LAT=3: back-to-back use stalls 3 cycles
        step(1, 1'b1, lw(5'd4), N, "b_lw_r4");
        step(1, 1'b1, alu(5'd4, 5'd4), S, "b_use_s1");
        step(1, 1'b1, alu(5'd4, 5'd4), S, "b_use_s2");
        step(1, 1'b1, alu(5'd4, 5'd4), S, "b_use_s3");
        step(1, 1'b1, alu(5'd4, 5'd4), N, "b_use_issue");

        // one independent instruction in between: 2 stalls
        step(1, 1'b1, lw(5'd4), N, "b_lw_r4b");
        step(1, 1'b1, alu(5'd10, 5'd11), N, "b_indep");
        step(1, 1'b1, alu(5'd4, 5'd4), S, "b_use2_s1");
        step(1, 1'b1, alu(5'd4, 5'd4), S, "b_use2_s2");
        step(1, 1'b1, alu(5'd4, 5'd4), N, "b_use2_issue");

        // store data: one cycle shorter than a normal use
        step(1, 1'b1, lw(5'd7), N, "b_lw_r7");
        step(1, 1'b1, sw(5'd8, 5'd7), S, "b_sw_s1");
        step(1, 1'b1, sw(5'd8, 5'd7), S, "b_sw_s2");
        step(1, 1'b1, sw(5'd8, 5'd7), N, "b_sw_issue");

        // loads keep aging through FLUSH
        step(1, 1'b1, lw(5'd4), N, "b_lw_r4c");
        step(1, 1'b1, br(5'd1, 5'd2), N, "b_beq_issue");
        step(1, 1'b1, nop(), F, "b_flush1");
        step(1, 1'b1, nop(), F, "b_flush2");
        step(1, 1'b1, alu(5'd4, 5'd4), N, "b_drained");
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        check_perf("b_perf_stall", b_stall_cnt, 32'd7);
        check_perf("b_perf_flush", b_flush_cnt, 32'd2);
`endif

        // bounded drain of the scoreboard
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
